// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts match events from a sequence detector's flag,
// measures the idle gap between consecutive matches and raises a level
// interrupt once the match count reaches a programmable threshold.
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_ack,
  output logic             match_pulse,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [GAP_W-1:0] gap,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // One-hot style encoding leaves spare codes; any of them falls back to ARMED.
  typedef enum logic [1:0] {
    ST_ARMED = 2'b01,
    ST_PEND  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             match_pulse_q, match_pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] timer_q, timer_d;
  logic             ack_take;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [GAP_W-1:0] sat_inc_gap(input logic [GAP_W-1:0] v);
    return (v == GAP_MAX) ? v : v + 1'b1;
  endfunction

  // Next-state and datapath update; priority clr > irq_ack > match.
  always_comb begin
    state_d       = state_q;
    match_pulse_d = flag;
    count_d       = count_q;
    overflow_d    = overflow_q;
    gap_d         = gap_q;
    timer_d       = timer_q;
    ack_take      = (state_q == ST_PEND) && irq_ack;

    if (clr) begin
      // A match coinciding with clr is dropped; match_pulse still follows flag.
      state_d    = ST_ARMED;
      count_d    = '0;
      overflow_d = 1'b0;
      gap_d      = '0;
      timer_d    = '0;
    end else begin
      // Gap timer runs independently of the interrupt handshake.
      if (flag) begin
        gap_d   = timer_q;
        timer_d = '0;
      end else begin
        timer_d = sat_inc_gap(timer_q);
      end

      if (ack_take) begin
        // Ack restarts counting; a same-cycle match becomes the first new count.
        count_d = flag ? CNT_ONE : '0;
      end else if (flag) begin
        if (count_q == CNT_MAX) overflow_d = 1'b1;
        count_d = sat_inc_cnt(count_q);
      end

      case (state_q)
        ST_ARMED: begin
          if ((thresh != '0) && (count_d >= thresh)) state_d = ST_PEND;
        end
        ST_PEND: begin
          // Threshold changes are ignored here; only an ack leaves PEND.
          if (irq_ack) state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARMED;
      match_pulse_q <= 1'b0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      gap_q         <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      match_pulse_q <= match_pulse_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      gap_q         <= gap_d;
      timer_q       <= timer_d;
    end
  end

  assign match_pulse = match_pulse_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign gap         = gap_q;
  assign irq         = (state_q == ST_PEND);

endmodule

// File: doc/seq_match_monitor.md
Name: seq_match_monitor

Overview:
- Downstream consumer of the serial sequence detector's `flag` output.
- Treats every clock cycle with `flag`=1 as one match event and counts matches in a saturating counter.
- Measures the idle gap between consecutive matches.
- Raises a level interrupt when the match count reaches a programmable threshold; the interrupt is held until acknowledged.

Parameters:
- CNT_W, 8, width of match counter and threshold.
- GAP_W, 8, width of gap timer and gap output.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- flag  input  1  match indication from the detector; each high cycle is one match.
- clr  input  1  synchronous soft clear of count, overflow, gap, timer and interrupt.
- thresh  input  CNT_W  interrupt threshold, sampled every cycle; 0 disables the interrupt.
- irq_ack  input  1  interrupt acknowledge, single-cycle or level.
- match_pulse  output  1  registered copy of flag.
- count  output  CNT_W  matches since last clear or ack; saturates at 2^CNT_W-1.
- overflow  output  1  sticky; set when a match arrives while count is saturated.
- gap  output  GAP_W  non-match cycles between the last two matches; saturates.
- irq  output  1  interrupt, level.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst` is synchronous, active-high.
  - `clk` and `rst` are the clock and reset port names.
- Reset values:
  - `match_pulse`, `count`, `overflow`, `gap` and `irq` all 0.
  - Internal gap timer 0.
  - State ARMED.
- Match definition: `flag`=1 sampled at rising edge k is one match. Back-to-back high cycles are distinct matches; S6->S7 chains on the detector produce two.
- Latency:
  - `match_pulse`, `count`, `gap`, `overflow` and `irq` reflect the match at edge k and are visible after edge k (one-cycle registered latency).
  - No combinational path from inputs to outputs.
- Counter:
  - On match, `count` <= `count`+1 unless `count` = 2^CNT_W-1.
  - When saturated, `count` holds and `overflow` <= 1.
  - `overflow` clears only on `rst` or `clr`.
- Gap timer:
  - Each non-match cycle, timer <= timer+1, saturating at 2^GAP_W-1.
  - On a match cycle: `gap` <= timer, and timer <= 0.
  - Back-to-back matches give `gap`=0.
  - The first match after reset or clear reports cycles elapsed since then, saturated.
- State machine, 2 states:
  - ARMED, `irq`=0.
    - If `thresh`!=0 and the next count value >= `thresh`, go to PEND; `irq`=1 from the same edge.
  - PEND, `irq`=1.
    - Counting continues normally.
    - On `irq_ack`=1: `count` <= 1 if a match occurs that same cycle, else 0; go to ARMED; `irq`=0.
    - A lingering `irq_ack` in ARMED has no effect.
  - Unreachable encodings recover to ARMED with `irq`=0.
- Threshold changes:
  - A `thresh` change while in PEND has no effect until ack.
  - If after ack the count already meets the new `thresh`, PEND re-enters on the next qualifying edge.
  - `thresh`=0 never asserts `irq`; if written 0 while in PEND, `irq` remains until ack.
- Priority, highest first: `rst` > `clr` > `irq_ack` > match.
  - `clr` forces ARMED and `irq`=0.
  - `clr` zeroes `count`, `overflow`, `gap` and timer.
  - A match in the `clr` cycle is dropped, but `match_pulse` still reflects `flag`.
- `rst` mid-operation: all state returns to reset values at that edge regardless of `flag`, `clr` or `irq_ack`.

Test Plan:
- `rst` 2 cycles, then `flag`=0 for 5 cycles -> all outputs 0; first subsequent match gives `gap`=5, `count`=1, `match_pulse` high one cycle after `flag`.
- `thresh`=3; matches at cycles 10, 11, 20 -> `count` 1, 2, 3; `gap` 0 then 8; `irq` rises after the cycle-20 edge and stays high; `irq_ack` at cycle 25 -> `count`=0, `irq`=0 next cycle.
- `thresh`=2, in PEND; `irq_ack` and `flag` both high in the same cycle -> `count`=1, state ARMED, `irq`=0; one more match -> `irq`=1.
- CNT_W=8, `thresh`=0, 257 matches -> `count` stops at 255, `overflow`=1 after the 256th match, `irq` never asserts; `clr` -> `count`=0, `overflow`=0.
- GAP_W=8, 300 idle cycles then a match -> `gap`=255; a further match 1 cycle later -> `gap`=0.
- `clr` and `flag` high in the same cycle while `count`=4 and `irq`=1 -> `count`=0, `irq`=0, `match_pulse`=1; assert `rst` during PEND -> all reset values next edge.
